// File: rtl/sound_glu_fifo_if.sv
// sound_glu_fifo_if
//   SDRAM client port used by the GLU to reach sound RAM.
//   master (GLU side):
//     mem_addr_o    22  word address
//     mem_wr_o       1  one-cycle write request
//     mem_rd_o       1  one-cycle read request
//     mem_byte_en_o  4  byte lanes (one-hot on writes, all on reads)
//     mem_data_o    32  write data, byte replicated in every lane
//     mem_q_i       32  read data
//     mem_ready_i    1  request complete (mem_q_i valid on reads)
//   slave (memory side): same signals, opposite directions.
interface sound_glu_fifo_if;
    logic [21:0] mem_addr_o;
    logic        mem_wr_o;
    logic        mem_rd_o;
    logic [3:0]  mem_byte_en_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_q_i;
    logic        mem_ready_i;

    modport master (
        output mem_addr_o, mem_wr_o, mem_rd_o, mem_byte_en_o, mem_data_o,
        input  mem_q_i, mem_ready_i
    );

    modport slave (
        input  mem_addr_o, mem_wr_o, mem_rd_o, mem_byte_en_o, mem_data_o,
        output mem_q_i, mem_ready_i
    );
endinterface

// File: rtl/sound_glu_fifo.sv
// sound_glu_fifo
//   IIgs sound GLU: decodes ctrl/data/ptr_lo/ptr_hi, routes data-register
//   accesses to the DOC5503 or to sound RAM, queues RAM writes in a FIFO
//   drained to SDRAM, serves RAM reads with prefetch semantics, and scales
//   and noise-gates the DOC stereo mix.
// Ports:
//   clk_logic, system_reset_n      clock, async active-low reset
//   reg_sel_i/addr/rw_n/strobe     register access from the bus decoder
//   reg_data_i / reg_data_o        register write / combinational read data
//   mem                            SDRAM client port (sound_glu_fifo_if.master)
//   doc_*                          DOC5503 access strobe, address and data
//   audio_l/r_i, audio_l/r_o       signed DOC mix in, scaled and gated out
module sound_glu_fifo #(
    parameter int unsigned ADDR_W               = 16,
    parameter int unsigned FIFO_DEPTH           = 8,
    parameter logic [31:0] MEM_BASE             = 32'h10000,
    parameter bit          NOISE_GATE_ENABLE    = 1'b1,
    parameter int unsigned NOISE_GATE_THRESHOLD = 48
) (
    input  logic                clk_logic,
    input  logic                system_reset_n,
    input  logic                reg_sel_i,
    input  logic [1:0]          reg_addr_i,
    input  logic                reg_rw_n_i,
    input  logic                reg_strobe_i,
    input  logic [7:0]          reg_data_i,
    output logic [7:0]          reg_data_o,
    sound_glu_fifo_if.master    mem,
    output logic                doc_cs_o,
    output logic                doc_we_o,
    output logic [7:0]          doc_addr_o,
    output logic [7:0]          doc_data_o,
    input  logic [7:0]          doc_data_i,
    input  logic signed [15:0]  audio_l_i,
    input  logic signed [15:0]  audio_r_i,
    output logic signed [15:0]  audio_l_o,
    output logic signed [15:0]  audio_r_o
);
    // The pointer register image is at least 16 bits so ptr_lo/ptr_hi always
    // read back; bits at or above ADDR_W are kept clear so it wraps there.
    localparam int unsigned     PW       = (ADDR_W > 16) ? ADDR_W : 16;
    localparam logic [PW-1:0]   PTR_MASK = PW'((33'd1 << ADDR_W) - 33'd1);
    localparam int unsigned     FIFO_AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned     ENTRY_W  = ADDR_W + 8;

    typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} state_t;

    state_t                 state_q;
    logic [6:0]             ctrl_q;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [7:0]             dataR_q;
    logic                   rdPend_q;
    logic [ADDR_W-1:0]      rdAddr_q;
    logic [ENTRY_W-1:0]     fifoMem_q [FIFO_DEPTH];
    logic [FIFO_AW:0]       wrIdx_q, rdIdx_q;
    logic [21:0]            memAddr_q;
    logic                   memWr_q, memRd_q;
    logic [3:0]             memBe_q;
    logic [31:0]            memData_q;
    logic signed [15:0]     s1L_q, s1R_q;

    logic access, dataAcc, ramMode, autoInc, ramWr, ramRd, docAcc;
    logic fifoEmpty, fifoFull, push, pop, overflow, rdDone, busy;
    logic [ADDR_W-1:0]  ptrEff, headAddr;
    logic [ENTRY_W-1:0] head;

    function automatic logic [21:0] wordAddr(input logic [ADDR_W-1:0] a);
        logic [31:0] sum;
        sum = MEM_BASE + 32'(a[ADDR_W-1:2]);
        return sum[21:0];
    endfunction

    // Magnitude is taken in 17 bits so -32768 compares correctly.
    function automatic logic [15:0] noiseGate(input logic [15:0] s);
        logic [16:0] mag;
        mag = s[15] ? (17'd0 - {1'b1, s}) : {1'b0, s};
        if (NOISE_GATE_ENABLE && (mag < 17'(NOISE_GATE_THRESHOLD)))
            return 16'h0000;
        return s;
    endfunction

    assign access    = reg_sel_i & reg_strobe_i;
    assign dataAcc   = access & (reg_addr_i == 2'd1);
    assign ramMode   = ctrl_q[6];
    assign autoInc   = ctrl_q[5];
    assign ramWr     = dataAcc & ramMode & ~reg_rw_n_i;
    assign ramRd     = dataAcc & ramMode & reg_rw_n_i;
    assign docAcc    = dataAcc & ~ramMode;
    assign ptrEff    = ptr_q[ADDR_W-1:0];

    assign fifoEmpty = (wrIdx_q == rdIdx_q);
    assign fifoFull  = (wrIdx_q[FIFO_AW] != rdIdx_q[FIFO_AW]) &&
                       (wrIdx_q[FIFO_AW-1:0] == rdIdx_q[FIFO_AW-1:0]);
    assign pop       = (state_q == ST_WR) & mem.mem_ready_i;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push      = ramWr & (~fifoFull | pop);
    assign overflow  = ramWr & fifoFull & ~pop;
    assign rdDone    = (state_q == ST_RD) & mem.mem_ready_i;
    assign busy      = ~fifoEmpty | (state_q != ST_IDLE);

    assign head      = fifoMem_q[rdIdx_q[FIFO_AW-1:0]];
    assign headAddr  = head[ENTRY_W-1:8];

    assign doc_cs_o   = docAcc;
    assign doc_we_o   = docAcc & ~reg_rw_n_i;
    assign doc_addr_o = ptr_q[7:0];
    assign doc_data_o = reg_data_i;

    assign mem.mem_addr_o    = memAddr_q;
    assign mem.mem_wr_o      = memWr_q;
    assign mem.mem_rd_o      = memRd_q;
    assign mem.mem_byte_en_o = memBe_q;
    assign mem.mem_data_o    = memData_q;

    // Register read mux; a DOC data read passes the DOC bus straight through.
    always_comb begin
        reg_data_o = 8'h00;
        if (reg_sel_i) begin
            unique case (reg_addr_i)
                2'd0:    reg_data_o = {busy, ctrl_q};
                2'd1:    reg_data_o = ramMode ? dataR_q : doc_data_i;
                2'd2:    reg_data_o = ptr_q[7:0];
                default: reg_data_o = ptr_q[15:8];
            endcase
        end
    end

    // Pointer update: explicit byte writes, else auto-increment on any data access.
    always_comb begin
        ptr_d = ptr_q;
        if (access && !reg_rw_n_i && reg_addr_i == 2'd2)
            ptr_d[7:0] = reg_data_i;
        else if (access && !reg_rw_n_i && reg_addr_i == 2'd3)
            ptr_d[15:8] = reg_data_i;
        else if (dataAcc && autoInc)
            ptr_d = ptr_q + PW'(1);
        ptr_d = ptr_d & PTR_MASK;
    end

    // Register file, FIFO write side and the read-prefetch bookkeeping.
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            ctrl_q   <= 7'h0F;
            ptr_q    <= '0;
            dataR_q  <= 8'h00;
            rdPend_q <= 1'b0;
            rdAddr_q <= '0;
            wrIdx_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (push)
                wrIdx_q <= wrIdx_q + 1'b1;
            if (access && !reg_rw_n_i && reg_addr_i == 2'd0)
                ctrl_q <= {reg_data_i[6:5], 1'b0, reg_data_i[3:0]};
            else if (overflow)
                ctrl_q[4] <= 1'b1;
            if (rdDone) begin
                dataR_q  <= mem.mem_q_i[{rdAddr_q[1:0], 3'b000} +: 8];
                rdPend_q <= 1'b0;
            end
            if (ramRd && !rdPend_q) begin
                rdPend_q <= 1'b1;
                rdAddr_q <= ptrEff;
            end
            if (docAcc && reg_rw_n_i)
                dataR_q <= doc_data_i;
        end
    end

    // FIFO storage needs no reset; validity lives in the index registers.
    always_ff @(posedge clk_logic) begin
        if (push)
            fifoMem_q[wrIdx_q[FIFO_AW-1:0]] <= {ptrEff, reg_data_i};
    end

    // Memory FSM: queued writes always go first, keeping program order.
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q   <= ST_IDLE;
            memWr_q   <= 1'b0;
            memRd_q   <= 1'b0;
            memAddr_q <= '0;
            memBe_q   <= 4'h0;
            memData_q <= '0;
            rdIdx_q   <= '0;
        end else begin
            memWr_q <= 1'b0;
            memRd_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!fifoEmpty) begin
                        state_q   <= ST_WR;
                        memWr_q   <= 1'b1;
                        memAddr_q <= wordAddr(headAddr);
                        memBe_q   <= 4'b0001 << headAddr[1:0];
                        memData_q <= {4{head[7:0]}};
                    end else if (rdPend_q) begin
                        state_q   <= ST_RD;
                        memRd_q   <= 1'b1;
                        memAddr_q <= wordAddr(rdAddr_q);
                        memBe_q   <= 4'hF;
                    end
                end
                ST_WR: begin
                    if (mem.mem_ready_i) begin
                        state_q <= ST_IDLE;
                        rdIdx_q <= rdIdx_q + 1'b1;
                    end
                end
                ST_RD: begin
                    if (mem.mem_ready_i)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Audio: stage 1 scales by (vol+1)/16, stage 2 applies the noise gate.
    logic [4:0]         gain;
    logic signed [20:0] gainS, inL, inR, prodL, prodR, shL, shR;
    assign gain  = {1'b0, ctrl_q[3:0]} + 5'd1;
    assign gainS = $signed({16'd0, gain});
    assign inL   = 21'(audio_l_i);
    assign inR   = 21'(audio_r_i);
    assign prodL = inL * gainS;
    assign prodR = inR * gainS;
    assign shL   = prodL >>> 4;
    assign shR   = prodR >>> 4;

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            s1L_q     <= '0;
            s1R_q     <= '0;
            audio_l_o <= '0;
            audio_r_o <= '0;
        end else begin
            s1L_q     <= shL[15:0];
            s1R_q     <= shR[15:0];
            audio_l_o <= noiseGate(s1L_q);
            audio_r_o <= noiseGate(s1R_q);
        end
    end
endmodule
